// File: rtl/move_collector.sv
// move_collector
// Drains the per-square move FIFOs in round-robin order. Each FIFO word holds
// SLOTS packed moves. Slots whose invalid flag (top bit) is set are dropped.
// Valid moves stream out one per cycle over a valid/ready link. done rises once
// every square reports done and every FIFO and the output register are empty.
module move_collector #(
    parameter int NSQ   = 64,
    parameter int MVW   = 19,
    parameter int SLOTS = 8,
    parameter int CNTW  = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic [NSQ-1:0]           sqDone_i,
    input  logic [NSQ-1:0]           fifoEmpty_i,
    input  logic [NSQ*SLOTS*MVW-1:0] fifoData_i,
    output logic [NSQ-1:0]           rden_o,
    output logic [MVW-1:0]           mvOut_o,
    output logic                     mvValid_o,
    input  logic                     mvReady_i,
    output logic [CNTW-1:0]          moveCount_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int WW = SLOTS * MVW;
    localparam int PW = (NSQ > 1) ? $clog2(NSQ) : 1;
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [2:0] {IDLE, SCAN, WAIT, UNPACK, DONE} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   lap_q, lap_d;
    logic [WW-1:0]   word_q, word_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [MVW-1:0]  mvOut_q, mvOut_d;
    logic            mvValid_q, mvValid_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [WW-1:0]   fifoWord;
    logic [MVW-1:0]  curSlot;
    logic [PW-1:0]   ptrNext;
    logic            accept;
    logic            outFree;
    logic            curEmpty;
    logic            lapEnd;
    logic            allClear;
    logic            slotInvalid;
    logic            slotAdvance;
    logic            lastSlot;

    // The output register can take a new move when it is empty or being drained
    assign accept      = mvValid_q & mvReady_i;
    assign outFree     = ~mvValid_q | mvReady_i;
    assign curEmpty    = fifoEmpty_i[ptr_q];
    assign ptrNext     = (ptr_q == PW'(NSQ - 1)) ? '0 : ptr_q + PW'(1);
    assign lapEnd      = (state_q == SCAN) & curEmpty & (lap_q == PW'(NSQ - 1));
    assign allClear    = (&sqDone_i) & (&fifoEmpty_i) & outFree;
    assign slotInvalid = curSlot[MVW-1];
    assign slotAdvance = (state_q == UNPACK) & (slotInvalid | outFree);
    assign lastSlot    = (slot_q == '0);

    // Select the FIFO q bus of the square under the pointer
    always_comb begin
        fifoWord = '0;
        for (int i = 0; i < NSQ; i++) begin
            if (ptr_q == PW'(i)) begin
                fifoWord = fifoData_i[i*WW +: WW];
            end
        end
    end

    // Select the move slot currently being unpacked from the word buffer
    always_comb begin
        curSlot = '0;
        for (int s = 0; s < SLOTS; s++) begin
            if (slot_q == SW'(s)) begin
                curSlot = word_q[s*MVW +: MVW];
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: scan for a non-empty FIFO, fetch one word, unpack it, repeat
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!curEmpty) begin
                    state_d = WAIT;
                end else if (lapEnd && allClear) begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                state_d = UNPACK;
            end
            UNPACK: begin
                if (slotAdvance && lastSlot) begin
                    state_d = SCAN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next values: pointer/lap bookkeeping, word capture, move output and counter
    always_comb begin
        ptr_d     = ptr_q;
        lap_d     = lap_q;
        word_d    = word_q;
        slot_d    = slot_q;
        mvOut_d   = mvOut_q;
        mvValid_d = mvValid_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = done_q;

        if (accept) begin
            mvValid_d = 1'b0;
            if (count_q != {CNTW{1'b1}}) begin
                count_d = count_q + CNTW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    count_d = '0;
                    done_d  = 1'b0;
                    ptr_d   = '0;
                    lap_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SCAN: begin
                if (!curEmpty) begin
                    lap_d = '0;
                end else begin
                    ptr_d = ptrNext;
                    if (lapEnd) begin
                        lap_d = '0;
                        if (allClear) begin
                            done_d = 1'b1;
                            busy_d = 1'b0;
                        end
                    end else begin
                        lap_d = lap_q + PW'(1);
                    end
                end
            end
            WAIT: begin
                word_d = fifoWord;
                slot_d = SW'(SLOTS - 1);
            end
            UNPACK: begin
                if (!slotInvalid && outFree) begin
                    mvOut_d   = curSlot;
                    mvValid_d = 1'b1;
                end
                if (slotAdvance) begin
                    if (lastSlot) begin
                        ptr_d = ptrNext;
                    end else begin
                        slot_d = slot_q - SW'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; a reset drops any partially unpacked word
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q     <= '0;
            lap_q     <= '0;
            word_q    <= '0;
            slot_q    <= '0;
            mvOut_q   <= '0;
            mvValid_q <= 1'b0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            lap_q     <= lap_d;
            word_q    <= word_d;
            slot_q    <= slot_d;
            mvOut_q   <= mvOut_d;
            mvValid_q <= mvValid_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Output decode: one-hot read strobe for a non-empty square under the pointer
    always_comb begin
        rden_o = '0;
        if (state_q == SCAN && !curEmpty) begin
            rden_o[ptr_q] = 1'b1;
        end
    end

    assign mvOut_o     = mvOut_q;
    assign mvValid_o   = mvValid_q;
    assign moveCount_o = count_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_move_collector.sv
// tb_move_collector
// Directed scenarios with randomized move contents and consumer back-pressure.
// A queue-per-square FIFO model feeds the collector; the expected move stream
// is derived from the FIFO contents by visiting squares in round-robin rounds.
module tb_move_collector;

    localparam int NSQ   = 64;
    localparam int MVW   = 19;
    localparam int SLOTS = 8;
    localparam int CNTW  = 8;
    localparam int WW    = SLOTS * MVW;

    logic              clk;
    logic              reset;
    logic              start;
    logic [NSQ-1:0]    sqDone;
    logic [NSQ-1:0]    fifoEmpty;
    logic [NSQ*WW-1:0] fifoData;
    logic [NSQ-1:0]    rden;
    logic [MVW-1:0]    mvOut;
    logic              mvValid;
    logic              mvReady;
    logic [CNTW-1:0]   moveCount;
    logic              busy;
    logic              done;

    logic [WW-1:0]  fq [NSQ][$];
    logic [WW-1:0]  popTmp;
    logic           pushReq;
    int             pushSq;
    logic [WW-1:0]  pushWordV;

    logic [MVW-1:0] expQ [$];
    int             expTotal;

    int             vectors;
    int             miscompares;
    int             cycle;
    int             acceptCnt;
    int             firstRden;
    int             firstValid;
    bit             rdenSeen;
    logic           randReady;
    logic           forcedReady;
    logic           prevValid;
    logic           prevReady;
    logic [MVW-1:0] prevOut;

    move_collector #(
        .NSQ   (NSQ),
        .MVW   (MVW),
        .SLOTS (SLOTS),
        .CNTW  (CNTW)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .sqDone_i    (sqDone),
        .fifoEmpty_i (fifoEmpty),
        .fifoData_i  (fifoData),
        .rden_o      (rden),
        .mvOut_o     (mvOut),
        .mvValid_o   (mvValid),
        .mvReady_i   (mvReady),
        .moveCount_o (moveCount),
        .busy_o      (busy),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Non-show-ahead FIFO model: q shows the popped word the cycle after rden
    always @(posedge clk) begin
        for (int i = 0; i < NSQ; i++) begin
            if (rden[i] && fq[i].size() > 0) begin
                popTmp = fq[i].pop_front();
                fifoData[i*WW +: WW] <= popTmp;
            end
        end
        if (pushReq) begin
            fq[pushSq].push_back(pushWordV);
        end
        for (int i = 0; i < NSQ; i++) begin
            fifoEmpty[i] <= (fq[i].size() == 0);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Consumer: random back-pressure or a fixed ready level
    initial begin
        mvReady = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            mvReady = randReady ? ($urandom_range(0, 3) != 0) : forcedReady;
        end
    end

    // Monitor: read-strobe rules, valid/ready hold rule and move scoreboard
    initial begin
        cycle     = 0;
        prevValid = 1'b0;
        prevReady = 1'b0;
        prevOut   = '0;
        forever begin
            @(negedge clk);
            cycle++;
            if (reset) begin
                prevValid = 1'b0;
            end else begin
                if (rden != '0) begin
                    rdenSeen = 1'b1;
                    if (firstRden < 0) firstRden = cycle;
                end
                if (mvValid && firstValid < 0) firstValid = cycle;
                checkOutput("rdenOneHot", 64'($onehot0(rden)), 64'd1);
                checkOutput("rdenNotEmpty", 64'(|(rden & fifoEmpty)), 64'd0);
                if (prevValid && !prevReady) begin
                    checkOutput("holdValid", 64'(mvValid), 64'd1);
                    checkOutput("holdOut", 64'(mvOut), 64'(prevOut));
                end
                if (mvValid && mvReady) begin
                    checkOutput("moveExpected", 64'(expQ.size() > 0), 64'd1);
                    if (expQ.size() > 0) begin
                        checkOutput("moveValue", 64'(mvOut), 64'(expQ.pop_front()));
                    end
                    acceptCnt++;
                end
                prevValid = mvValid;
                prevReady = mvReady;
                prevOut   = mvOut;
            end
        end
    end

    function automatic logic [WW-1:0] makeWord(input logic [SLOTS-1:0] mask);
        logic [WW-1:0]  w;
        logic [MVW-1:0] mv;
        w = '0;
        for (int s = 0; s < SLOTS; s++) begin
            mv = MVW'($urandom);
            mv[MVW-1] = ~mask[s];
            w[s*MVW +: MVW] = mv;
        end
        return w;
    endfunction

    function automatic void addWord(input logic [WW-1:0] w);
        logic [MVW-1:0] mv;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            mv = w[s*MVW +: MVW];
            if (!mv[MVW-1]) begin
                expQ.push_back(mv);
                expTotal++;
            end
        end
    endfunction

    // Reference order: round r takes word r of every square holding more than r words
    task automatic buildExpected();
        expQ.delete();
        expTotal = 0;
        for (int r = 0; r < NSQ; r++) begin
            for (int sq = 0; sq < NSQ; sq++) begin
                if (fq[sq].size() > r) addWord(fq[sq][r]);
            end
        end
    endtask

    task automatic pushWord(input int sq, input logic [WW-1:0] w);
        @(posedge clk);
        #1;
        pushReq   = 1'b1;
        pushSq    = sq;
        pushWordV = w;
        @(posedge clk);
        #1;
        pushReq   = 1'b0;
    endtask

    // One-cycle start pulse
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic newTest();
        acceptCnt  = 0;
        firstRden  = -1;
        firstValid = -1;
        rdenSeen   = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_doneInTime"}, 64'(done), 64'd1);
    endtask

    task automatic finishRun(input string tag, input int budget);
        int n;
        int expCount;
        waitDone(tag, budget, n);
        expCount = (expTotal > 255) ? 255 : expTotal;
        checkOutput({tag, "_moveCount"}, 64'(moveCount), 64'(expCount));
        checkOutput({tag, "_allDrained"}, 64'(expQ.size()), 64'd0);
        checkOutput({tag, "_busyLow"}, 64'(busy), 64'd0);
        checkOutput({tag, "_validLow"}, 64'(mvValid), 64'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rden"}, 64'(rden), 64'd0);
        checkOutput({tag, "_mvValid"}, 64'(mvValid), 64'd0);
        checkOutput({tag, "_mvOut"}, 64'(mvOut), 64'd0);
        checkOutput({tag, "_moveCount"}, 64'(moveCount), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WW-1:0] w;
        int n;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        start       = 1'b0;
        sqDone      = '1;
        pushReq     = 1'b0;
        pushSq      = 0;
        pushWordV   = '0;
        randReady   = 1'b0;
        forcedReady = 1'b1;
        expTotal    = 0;
        newTest();

        // Reset values
        #1 reset = 1'b1;
        #2;
        checkResetValues("reset");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // 1: nothing to collect, every square done
        $display("[TB] test 1: empty scan");
        newTest();
        buildExpected();
        applyStimulus();
        checkOutput("t1_busy", 64'(busy), 64'd1);
        waitDone("t1", 200, n);
        checkOutput("t1_doneLatency", 64'(n), 64'd65);
        checkOutput("t1_moveCount", 64'(moveCount), 64'd0);
        checkOutput("t1_noRden", 64'(rdenSeen), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("t1_doneHeld", 64'(done), 64'd1);
        checkOutput("t1_busyLow", 64'(busy), 64'd0);

        // 2: square 12, slots 7 and 2 valid, latency from rden
        $display("[TB] test 2: two moves from square 12");
        newTest();
        w = makeWord(8'h00);
        w[7*MVW +: MVW] = 19'h00C1C;
        w[2*MVW +: MVW] = 19'h00C14;
        pushWord(12, w);
        buildExpected();
        applyStimulus();
        finishRun("t2", 400);
        checkOutput("t2_accepts", 64'(acceptCnt), 64'd2);
        checkOutput("t2_latency", 64'(firstValid - firstRden), 64'd3);

        // 3: consumer stalls on the first move
        $display("[TB] test 3: back-pressure on first move");
        newTest();
        pushWord(20, makeWord(8'b1100_0101));
        buildExpected();
        forcedReady = 1'b0;
        applyStimulus();
        n = 0;
        while (!mvValid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t3_validSeen", 64'(mvValid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("t3_stallValid", 64'(mvValid), 64'd1);
            checkOutput("t3_stallOut", 64'(mvOut), 64'(expQ[0]));
            checkOutput("t3_stallCount", 64'(moveCount), 64'd0);
        end
        forcedReady = 1'b1;
        finishRun("t3", 400);

        // 4: wrap-around fairness, an all-invalid word, and a start while busy
        $display("[TB] test 4: squares 0 and 63, two words each");
        newTest();
        pushWord(0, makeWord(SLOTS'($urandom) | 8'h01));
        pushWord(0, makeWord(SLOTS'($urandom) | 8'h80));
        pushWord(63, makeWord(SLOTS'($urandom) | 8'h10));
        pushWord(63, makeWord(SLOTS'($urandom)));
        pushWord(30, makeWord(8'h00));
        buildExpected();
        randReady = 1'b1;
        applyStimulus();
        repeat (10) @(negedge clk);
        applyStimulus();
        finishRun("t4", 2000);

        // 5: square 5 not done yet, word arrives late
        $display("[TB] test 5: late word on square 5");
        newTest();
        buildExpected();
        sqDone[5] = 1'b0;
        applyStimulus();
        repeat (150) @(negedge clk);
        checkOutput("t5_notDone", 64'(done), 64'd0);
        checkOutput("t5_stillBusy", 64'(busy), 64'd1);
        w = makeWord(SLOTS'($urandom) | 8'h81);
        pushWord(5, w);
        addWord(w);
        @(posedge clk);
        #1 sqDone[5] = 1'b1;
        finishRun("t5", 1000);

        // 6: reset in the middle of unpacking, then collect the rest
        $display("[TB] test 6: reset mid-unpack");
        newTest();
        randReady   = 1'b0;
        forcedReady = 1'b1;
        pushWord(3, makeWord(8'hFF));
        pushWord(3, makeWord(8'hFF));
        pushWord(40, makeWord(8'hFF));
        buildExpected();
        applyStimulus();
        n = 0;
        while (acceptCnt < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_threeAccepted", 64'(acceptCnt >= 3), 64'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checkResetValues("t6_reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        newTest();
        buildExpected();
        applyStimulus();
        finishRun("t6", 1000);
        checkOutput("t6_accepts", 64'(acceptCnt), 64'd16);

        // 7: move counter saturation
        $display("[TB] test 7: counter saturation");
        newTest();
        randReady = 1'b1;
        for (int sq = 0; sq < 40; sq++) begin
            pushWord(sq, makeWord(8'hFF));
        end
        buildExpected();
        applyStimulus();
        finishRun("t7", 3000);
        checkOutput("t7_accepts", 64'(acceptCnt), 64'd320);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
